// File: rtl/vx_sp_ram_arbiter.sv
// vx_sp_ram_arbiter
//   Lets NUM_REQS requesters share one single-port RAM macro. The macro does one
//   read or one write per cycle, returns read data registered one cycle later, and
//   holds that data until the next read. The macro itself is instantiated by the
//   parent of this block.
//
//   Requesters are granted round-robin. Each requester has a valid/ready request
//   channel and a valid/ready read-response channel. The response channel supports
//   backpressure.
//
//   Optional feature: when VX_SP_RAM_ARBITER_INIT_EN is defined, the arbiter zero-fills
//   every RAM word after reset and holds off all requests until that fill is done.
//   When the macro is not defined, init_done is tied high.
//
// Ports
//   clk, reset        clock; reset is synchronous and active-high
//   req_valid/req_rw  per-requester request valid; rw=1 means write, rw=0 means read
//   req_wren          per-requester byte-lane enables, used for writes only
//   req_addr          per-requester address
//   req_wdata         per-requester write data
//   req_ready         one-hot grant
//   rsp_valid         one-hot read-response valid
//   rsp_data          shared read data, equal to ram_rdata
//   rsp_ready         per-requester response accept
//   ram_*             RAM macro interface
//   init_done         high when the arbiter is accepting requests
module vx_sp_ram_arbiter #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 32,
   parameter int SIZE     = 256,
   parameter int WRENW    = 4,
   parameter int ADDRW    = $clog2(SIZE)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS-1:0]       req_rw,
   input  logic [NUM_REQS*WRENW-1:0] req_wren,
   input  logic [NUM_REQS*ADDRW-1:0] req_addr,
   input  logic [NUM_REQS*DATAW-1:0] req_wdata,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic [NUM_REQS-1:0]       rsp_valid,
   output logic [DATAW-1:0]          rsp_data,
   input  logic [NUM_REQS-1:0]       rsp_ready,
   output logic                      ram_read,
   output logic                      ram_write,
   output logic [WRENW-1:0]          ram_wren,
   output logic [ADDRW-1:0]          ram_addr,
   output logic [DATAW-1:0]          ram_wdata,
   input  logic [DATAW-1:0]          ram_rdata,
   output logic                      init_done
);

   localparam int PTRW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   typedef enum logic {RSP_IDLE, RSP_PEND} rsp_state_t;

   rsp_state_t      rsp_state, rsp_state_n;
   logic [PTRW-1:0] owner, owner_n;
   logic [PTRW-1:0] rr_ptr, rr_ptr_n;

   logic             init_wr;
   logic [ADDRW-1:0] init_addr;

`ifdef VX_SP_RAM_ARBITER_INIT_EN
   typedef enum logic {INIT_RUN, INIT_DONE} init_state_t;

   init_state_t      init_state, init_state_n;
   logic [ADDRW-1:0] init_addr_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         init_state <= INIT_RUN;
         init_addr  <= '0;
      end else begin
         init_state <= init_state_n;
         init_addr  <= init_addr_n;
      end
   end

   always_comb begin
      init_state_n = init_state;
      init_addr_n  = init_addr;
      init_wr      = 1'b0;
      if (init_state == INIT_RUN && !reset) begin
         init_wr = 1'b1;
         if (init_addr == ADDRW'(SIZE - 1)) begin
            init_state_n = INIT_DONE;
         end else begin
            init_addr_n = init_addr + ADDRW'(1);
         end
      end
   end

   assign init_done = (init_state == INIT_DONE);
`else
   assign init_wr   = 1'b0;
   assign init_addr = '0;
   assign init_done = 1'b1;
`endif

   assign rsp_data = ram_rdata;

   logic pending;
   logic rsp_fire;
   logic read_blocked;
   logic grant_any;
   int   win;
   int   idx;

   always_comb begin
      rsp_state_n  = rsp_state;
      owner_n      = owner;
      rr_ptr_n     = rr_ptr;
      req_ready    = '0;
      rsp_valid    = '0;
      ram_read     = 1'b0;
      ram_write    = 1'b0;
      ram_wren     = '0;
      ram_addr     = '0;
      ram_wdata    = '0;
      grant_any    = 1'b0;
      win          = 0;
      idx          = 0;

      pending = (rsp_state == RSP_PEND);
      if (pending) begin
         rsp_valid[owner] = 1'b1;
      end
      rsp_fire     = pending & rsp_ready[owner];
      // A read may be granted in the same cycle that the previous response retires.
      // This keeps back-to-back reads running at one per cycle.
      read_blocked = pending & ~rsp_fire;

      if (rsp_fire) begin
         rsp_state_n = RSP_IDLE;
      end

      if (init_wr) begin
         ram_write = 1'b1;
         ram_wren  = '1;
         ram_addr  = init_addr;
      end else if (!reset && init_done) begin
         // Scan upward from the round-robin pointer, wrapping past NUM_REQS-1.
         for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + int'(k);
            if (idx >= NUM_REQS) begin
               idx = idx - NUM_REQS;
            end
            if (!grant_any && req_valid[PTRW'(idx)] &&
                (req_rw[PTRW'(idx)] || !read_blocked)) begin
               grant_any = 1'b1;
               win       = idx;
            end
         end

         if (grant_any) begin
            req_ready[PTRW'(win)] = 1'b1;
            rr_ptr_n = (win == NUM_REQS - 1) ? '0 : PTRW'(win + 1);
            ram_addr = req_addr[win*ADDRW +: ADDRW];
            if (req_rw[PTRW'(win)]) begin
               ram_write = 1'b1;
               ram_wren  = req_wren[win*WRENW +: WRENW];
               ram_wdata = req_wdata[win*DATAW +: DATAW];
            end else begin
               ram_read    = 1'b1;
               rsp_state_n = RSP_PEND;
               owner_n     = PTRW'(win);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_state <= RSP_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
      end else begin
         rsp_state <= rsp_state_n;
         owner     <= owner_n;
         rr_ptr    <= rr_ptr_n;
      end
   end

endmodule

// File: tb/tb_vx_sp_ram_arbiter.sv
module tb_vx_sp_ram_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SZ = 16;
   localparam int WW = 4;
   localparam int AW = 4;
   localparam int LW = DW / WW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0, req_rw = '0, rsp_ready = '1;
   logic [N*WW-1:0] req_wren = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            ram_read, ram_write, init_done;
   logic [WW-1:0]   ram_wren;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata = '0;
   logic            env_clear = 1'b1;

   always #5 clk = ~clk;

   vx_sp_ram_arbiter #(
      .NUM_REQS(N), .DATAW(DW), .SIZE(SZ), .WRENW(WW), .ADDRW(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_wren(req_wren),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .ram_read(ram_read), .ram_write(ram_write), .ram_wren(ram_wren),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .init_done(init_done)
   );

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [WW-1:0] en);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < WW; b++) if (en[b]) r[b*LW +: LW] = new_w[b*LW +: LW];
      return r;
   endfunction

   // RAM macro environment: registered read, data held while no read.
   logic [DW-1:0] ram_mem [SZ];
   always @(posedge clk) begin
      if (env_clear) begin
         for (int a = 0; a < SZ; a++) ram_mem[a] <= '0;
      end else begin
         if (ram_write) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_wren);
         if (ram_read)  ram_rdata <= ram_mem[ram_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: transaction-level view of the arbiter.
   logic [DW-1:0] ref_mem [SZ];
   bit            m_ok = 0;
   bit            m_pend = 0;
   int            m_owner = 0;
   int            m_ptr = 0;
   int            m_init = SZ;
   logic [DW-1:0] m_data = '0;

   always @(negedge clk) begin : cmp
      logic [N-1:0]  e_ready, e_rspv;
      logic          e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [WW-1:0] e_wren;
      logic [DW-1:0] e_wdata;
      bit            fire, init_busy;
      int            w, i;

      fire      = m_pend && rsp_ready[m_owner];
      init_busy = (m_init < SZ);
      e_ready = '0; e_rspv = '0; e_rd = 0; e_wr = 0;
      e_addr = '0; e_wren = '0; e_wdata = '0; w = -1;
      if (m_pend) e_rspv[m_owner] = 1'b1;

      if (!reset && init_busy) begin
         e_wr = 1; e_addr = AW'(m_init); e_wren = '1; e_wdata = '0;
      end else if (!reset) begin
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (w < 0 && req_valid[i] && (req_rw[i] || !m_pend || fire)) w = i;
         end
         if (w >= 0) begin
            e_ready[w] = 1'b1;
            e_addr = req_addr[w*AW +: AW];
            if (req_rw[w]) begin
               e_wr = 1; e_wren = req_wren[w*WW +: WW]; e_wdata = req_wdata[w*DW +: DW];
            end else begin
               e_rd = 1;
            end
         end
      end

      if (m_ok) begin
         check("req_ready", req_ready, e_ready);
         check("rsp_valid", rsp_valid, e_rspv);
         check("ram_read", ram_read, e_rd);
         check("ram_write", ram_write, e_wr);
         check("init_done", init_done, !init_busy);
         if (e_rd || e_wr) check("ram_addr", ram_addr, e_addr);
         if (e_wr) begin
            check("ram_wren", ram_wren, e_wren);
            check("ram_wdata", ram_wdata, e_wdata);
         end
         if (m_pend) check("rsp_data", rsp_data, m_data);
      end

      if (reset) begin
         if (!m_ok) for (int a = 0; a < SZ; a++) ref_mem[a] = '0;
         m_ok = 1; m_pend = 0; m_ptr = 0;
`ifdef VX_SP_RAM_ARBITER_INIT_EN
         m_init = 0;
`else
         m_init = SZ;
`endif
      end else if (init_busy) begin
         ref_mem[m_init] = '0;
         m_init++;
      end else begin
         if (fire) m_pend = 0;
         if (w >= 0) begin
            m_ptr = (w + 1) % N;
            if (e_wr) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wdata, e_wren);
            else begin m_pend = 1; m_owner = w; m_data = ref_mem[e_addr]; end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic set_req(input int r, input logic rw, input int a,
                          input logic [DW-1:0] d, input logic [WW-1:0] en);
      req_valid[r] = 1'b1;
      req_rw[r] = rw;
      req_addr[r*AW +: AW] = AW'(a);
      req_wdata[r*DW +: DW] = d;
      req_wren[r*WW +: WW] = en;
   endtask

   task automatic do_reset();
      step(); reset = 1'b1; req_valid = '0;
      step(); reset = 1'b0;
`ifdef VX_SP_RAM_ARBITER_INIT_EN
      repeat (SZ) step();
`endif
   endtask

   logic [N-1:0] exp_v;

   initial begin
      step(); env_clear = 1'b0;
      step();
      settle();
      check("reset_req_ready", req_ready, 4'b0000);
      check("reset_rsp_valid", rsp_valid, 4'b0000);
      check("reset_ram_read", ram_read, 1'b0);
      check("reset_ram_write", ram_write, 1'b0);
      step(); reset = 1'b0;

`ifdef VX_SP_RAM_ARBITER_INIT_EN
      for (int r = 0; r < N; r++) set_req(r, 1'b0, 3, '0, '0);
      for (int c = 0; c < SZ; c++) begin
         settle();
         check("init_busy_done", init_done, 1'b0);
         check("init_busy_ready", req_ready, 4'b0000);
         step();
      end
      settle();
      check("init_end_done", init_done, 1'b1);
      check("init_end_ready", req_ready, 4'b0001);
      step(); req_valid = '0;
      settle();
      check("init_zero_data", rsp_data, 32'h0);
`else
      settle();
      check("init_done_tied", init_done, 1'b1);
`endif

      // write then read back
      step(); req_valid = '0; set_req(0, 1'b1, 5, 32'hDEADBEEF, 4'hF);
      settle();
      check("t1_wr_ready", req_ready, 4'b0001);
      check("t1_wr_strobe", ram_write, 1'b1);
      step(); req_valid = '0; set_req(0, 1'b0, 5, '0, '0);
      settle();
      check("t1_rd_strobe", ram_read, 1'b1);
      step(); req_valid = '0;
      settle();
      check("t1_rsp_valid", rsp_valid, 4'b0001);
      check("t1_rsp_data", rsp_data, 32'hDEADBEEF);

      // continuous reads from all requesters rotate one grant per cycle
      do_reset();
      rsp_ready = '1;
      for (int r = 0; r < N; r++) set_req(r, 1'b0, r, '0, '0);
      for (int c = 0; c < 8; c++) begin
         settle();
         exp_v = '0; exp_v[c % N] = 1'b1;
         check("t2_grant", req_ready, exp_v);
         if (c > 0) begin
            exp_v = '0; exp_v[(c - 1) % N] = 1'b1;
            check("t2_rsp_valid", rsp_valid, exp_v);
         end
         step();
      end
      req_valid = '0;

      // partial-lane write
      step(); set_req(1, 1'b1, 9, 32'h11223344, 4'hF);
      step(); req_valid = '0; set_req(1, 1'b1, 9, 32'h0000AB00, 4'b0010);
      step(); req_valid = '0; set_req(1, 1'b0, 9, '0, '0);
      settle();
      check("t4_rd_ready", req_ready, 4'b0010);
      step(); req_valid = '0;
      settle();
      check("t4_rsp_data", rsp_data, 32'h1122AB44);

      // response backpressure: writes pass, reads stall
      step(); set_req(1, 1'b1, 7, 32'hCAFE0001, 4'hF);
      step(); req_valid = '0; set_req(0, 1'b1, 8, 32'h55AA55AA, 4'hF);
      do_reset();
      rsp_ready = 4'b1101;
      set_req(1, 1'b0, 7, '0, '0);
      settle();
      check("t3_rd1_ready", req_ready, 4'b0010);
      step(); req_valid = '0;
      set_req(2, 1'b0, 8, '0, '0);
      set_req(3, 1'b1, 10, 32'h00000077, 4'hF);
      settle();
      check("t3_wr3_ready", req_ready, 4'b1000);
      check("t3_rsp1_valid", rsp_valid, 4'b0010);
      check("t3_rsp1_data", rsp_data, 32'hCAFE0001);
      for (int c = 0; c < 4; c++) begin
         step(); req_valid[3] = 1'b0;
         settle();
         check("t3_stall_ready", req_ready, 4'b0000);
         check("t3_stall_data", rsp_data, 32'hCAFE0001);
      end
      step(); rsp_ready = '1;
      settle();
      check("t3_rd2_ready", req_ready, 4'b0100);
      step(); req_valid = '0;
      settle();
      check("t3_rsp2_valid", rsp_valid, 4'b0100);
      check("t3_rsp2_data", rsp_data, 32'h55AA55AA);

      // reset while a response is outstanding
      step(); set_req(2, 1'b0, 7, '0, '0); rsp_ready = 4'b1011;
      step(); req_valid = '0; reset = 1'b1;
      settle();
      check("t5_pre_rsp_valid", rsp_valid, 4'b0100);
      step(); reset = 1'b0; rsp_ready = '1;
      for (int r = 0; r < N; r++) set_req(r, 1'b0, r, '0, '0);
      settle();
      check("t5_post_rsp_valid", rsp_valid, 4'b0000);
`ifdef VX_SP_RAM_ARBITER_INIT_EN
      check("t5_post_init", init_done, 1'b0);
      repeat (SZ) step();
      settle();
`endif
      check("t5_ptr_zero", req_ready, 4'b0001);
      step(); req_valid = '0;

      // randomized traffic, checked by the model
      for (int c = 0; c < 3000; c++) begin
         step();
         reset = ($urandom_range(0, 299) == 0);
         for (int r = 0; r < N; r++) begin
            req_valid[r] = ($urandom_range(0, 2) != 0);
            req_rw[r] = $urandom_range(0, 1) == 1;
            req_addr[r*AW +: AW] = AW'($urandom_range(0, SZ - 1));
            req_wdata[r*DW +: DW] = $urandom;
            req_wren[r*WW +: WW] = WW'($urandom_range(0, 15));
            rsp_ready[r] = ($urandom_range(0, 3) != 0);
         end
      end
      step(); req_valid = '0;
      step();
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
